// File: rtl/prbs_sym_gen.sv
// prbs_sym_gen: Fibonacci-LFSR PRBS source emitting SYM_BITS-wide symbols
// with a valid/ready output stage.
// Build option: PRBS_LOCKUP_GUARD_EN replaces an all-zero seed with all-ones
// and raises a sticky lockup_err flag. When it is undefined, a zero seed is
// loaded unchanged and lockup_err is tied low.
module prbs_sym_gen #(
  parameter int REG_LEN  = 4,
  parameter int SYM_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                seed_load,
  input  logic [REG_LEN-1:0]  seed,
  input  logic                sym_ready,
  output logic                sym_valid,
  output logic [SYM_BITS-1:0] sym_data,
  output logic                sym_sop,
  output logic                lockup_err
);

  if (REG_LEN < 2 || REG_LEN > 13) begin : g_bad_reg_len
    $error("prbs_sym_gen: REG_LEN %0d outside 2..13", REG_LEN);
  end
  if (SYM_BITS < 1 || SYM_BITS > 8) begin : g_bad_sym_bits
    $error("prbs_sym_gen: SYM_BITS %0d outside 1..8", SYM_BITS);
  end

  // Feedback tap positions for each supported LFSR length, as a bit mask.
  function automatic logic [12:0] tap_mask(input int len);
    case (len)
      2:       return 13'h0003;
      3:       return 13'h0005;
      4:       return 13'h0009;
      5:       return 13'h0012;
      6:       return 13'h0021;
      7:       return 13'h0044;
      8:       return 13'h008E;
      9:       return 13'h0108;
      10:      return 13'h0204;
      11:      return 13'h0402;
      12:      return 13'h0829;
      13:      return 13'h100D;
      default: return 13'h0000;
    endcase
  endfunction

  localparam logic [12:0]        TAP_MASK = tap_mask(REG_LEN);
  localparam logic [REG_LEN-1:0] TAPS     = TAP_MASK[REG_LEN-1:0];
  localparam logic [REG_LEN-1:0] ONES     = '1;

  logic [REG_LEN-1:0]  state_q, state_d;
  logic                valid_q, valid_d;
  logic [SYM_BITS-1:0] data_q, data_d;
  logic                sop_q, sop_d;
  logic [REG_LEN-1:0]  state_adv;
  logic [SYM_BITS-1:0] sym_next;
  logic [REG_LEN-1:0]  seed_eff;
  logic                load;

`ifdef PRBS_LOCKUP_GUARD_EN
  logic lockup_err_q, lockup_err_d;
  assign seed_eff   = (seed == '0) ? ONES : seed;
  assign lockup_err = lockup_err_q;
`else
  assign seed_eff   = seed;
  assign lockup_err = 1'b0;
`endif

  // Unrolled LFSR: SYM_BITS serial steps per cycle; the earliest bit lands in the MSB.
  always_comb begin : p_unroll
    logic [REG_LEN-1:0] st;
    st       = state_q;
    sym_next = '0;
    for (int i = 0; i < SYM_BITS; i++) begin
      sym_next[SYM_BITS-1-i] = st[REG_LEN-1];
      st = {st[REG_LEN-2:0], ^(st & TAPS)};
    end
    state_adv = st;
  end

  assign load = en && (!valid_q || sym_ready);

  // Next-state: a reseed wins, then a symbol load, then draining an accepted symbol.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
`ifdef PRBS_LOCKUP_GUARD_EN
    lockup_err_d = lockup_err_q;
`endif
    if (seed_load) begin
      state_d = seed_eff;
      valid_d = 1'b0;
`ifdef PRBS_LOCKUP_GUARD_EN
      if (seed == '0) lockup_err_d = 1'b1;
`endif
    end else if (load) begin
      state_d = state_adv;
      data_d  = sym_next;
      sop_d   = (state_q == ONES);
      valid_d = 1'b1;
    end else if (valid_q && sym_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset parks the LFSR at all-ones so the stream restarts at symbol 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ONES;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
`ifdef PRBS_LOCKUP_GUARD_EN
      lockup_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
`ifdef PRBS_LOCKUP_GUARD_EN
      lockup_err_q <= lockup_err_d;
`endif
    end
  end

  assign sym_valid = valid_q;
  assign sym_data  = data_q;
  assign sym_sop   = sop_q;

endmodule

// File: tb/tb_prbs_sym_gen.sv
// Directed bench for prbs_sym_gen: a REG_LEN=4/SYM_BITS=4 instance and a
// REG_LEN=4/SYM_BITS=1 instance share clock and reset.
module tb_prbs_sym_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en4 = 1'b0, ready4 = 1'b1, seed_load4 = 1'b0;
  logic [3:0] seed4 = 4'hF;
  logic       valid4, sop4, lock4;
  logic [3:0] data4;

  logic       en1 = 1'b0, ready1 = 1'b1, seed_load1 = 1'b0;
  logic [3:0] seed1 = 4'hF;
  logic       valid1, sop1, lock1;
  logic [0:0] data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs_sym_gen #(.REG_LEN(4), .SYM_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .seed_load(seed_load4), .seed(seed4),
    .sym_ready(ready4), .sym_valid(valid4), .sym_data(data4), .sym_sop(sop4),
    .lockup_err(lock4)
  );

  prbs_sym_gen #(.REG_LEN(4), .SYM_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .seed_load(seed_load1), .seed(seed1),
    .sym_ready(ready1), .sym_valid(valid1), .sym_data(data1), .sym_sop(sop1),
    .lockup_err(lock1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic v, input logic [3:0] d, input logic s);
    check_val({tag, " valid"}, 32'(valid4), 32'(v));
    check_val({tag, " data"},  32'(data4),  32'(d));
    check_val({tag, " sop"},   32'(sop4),   32'(s));
  endtask

  initial begin
    logic [14:0] pat;
    logic [3:0]  exp4 [5];
    pat = 15'b111101011001000;
    exp4[0] = 4'hF; exp4[1] = 4'h5; exp4[2] = 4'h9; exp4[3] = 4'h1; exp4[4] = 4'hE;

    // Reset state
    #3;
    check4("rst4", 1'b0, 4'h0, 1'b0);
    check_val("rst4 lock", 32'(lock4), 32'd0);
    check_val("rst1 valid", 32'(valid1), 32'd0);
    check_val("rst1 data", 32'(data1), 32'd0);
    #4 rst_n = 1'b1;
    tick();
    tick();
    check_val("idle valid4", 32'(valid4), 32'd0);

    // SYM_BITS=1: 15-bit period, sop at 0, 15, 30
    en1 = 1'b1;
    check_val("en1 pre valid", 32'(valid1), 32'd0);
    for (int k = 0; k < 31; k++) begin
      tick();
      check_val($sformatf("s1 valid %0d", k), 32'(valid1), 32'd1);
      check_val($sformatf("s1 bit %0d", k), 32'(data1), 32'(pat[14 - (k % 15)]));
      check_val($sformatf("s1 sop %0d", k), 32'(sop1), 32'((k % 15) == 0));
    end
    // Handshake with en=0 drops valid, LFSR holds; resume gives symbol 31
    en1 = 1'b0;
    tick();
    check_val("s1 drop valid", 32'(valid1), 32'd0);
    tick();
    check_val("s1 still idle", 32'(valid1), 32'd0);
    en1 = 1'b1;
    tick();
    check_val("s1 resume valid", 32'(valid1), 32'd1);
    check_val("s1 resume bit", 32'(data1), 32'(pat[14 - 1]));
    check_val("s1 resume sop", 32'(sop1), 32'd0);
    en1 = 1'b0;

    // SYM_BITS=4 streaming from reset state
    en4 = 1'b1;
    check_val("en4 pre valid", 32'(valid4), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check4($sformatf("s4 sym %0d", k), 1'b1, exp4[k], k == 0);
    end

    // Back-pressure: reseed to all-ones, hold 0xF for 5 cycles, then 0x5
    seed_load4 = 1'b1; seed4 = 4'hF;
    tick();
    check_val("reseed valid", 32'(valid4), 32'd0);
    seed_load4 = 1'b0; ready4 = 1'b0;
    tick();
    check4("bp first", 1'b1, 4'hF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check4($sformatf("bp hold %0d", k), 1'b1, 4'hF, 1'b1);
    end
    ready4 = 1'b1;
    tick();
    check4("bp release", 1'b1, 4'h5, 1'b0);

    // Seed load while stalled
    ready4 = 1'b0;
    tick();
    check4("stall", 1'b1, 4'h5, 1'b0);
    seed_load4 = 1'b1; seed4 = 4'b1010;
    tick();
    check_val("seedA valid", 32'(valid4), 32'd0);
    seed_load4 = 1'b0;
    tick();
    check4("seedA sym", 1'b1, 4'hA, 1'b0);

    // Zero seed
    ready4 = 1'b1;
    seed_load4 = 1'b1; seed4 = 4'h0;
    tick();
    check_val("seed0 valid", 32'(valid4), 32'd0);
    seed_load4 = 1'b0;
    tick();
`ifdef PRBS_LOCKUP_GUARD_EN
    check4("seed0 sym0", 1'b1, 4'hF, 1'b1);
    check_val("seed0 lock0", 32'(lock4), 32'd1);
    tick();
    check4("seed0 sym1", 1'b1, 4'h5, 1'b0);
    check_val("seed0 lock1", 32'(lock4), 32'd1);
    seed_load4 = 1'b1; seed4 = 4'hF;
    tick();
    seed_load4 = 1'b0;
    tick();
    check_val("lock sticky", 32'(lock4), 32'd1);
`else
    check4("seed0 sym0", 1'b1, 4'h0, 1'b0);
    check_val("seed0 lock0", 32'(lock4), 32'd0);
    tick();
    check4("seed0 sym1", 1'b1, 4'h0, 1'b0);
    check_val("seed0 lock1", 32'(lock4), 32'd0);
    seed_load4 = 1'b1; seed4 = 4'hF;
    tick();
    seed_load4 = 1'b0;
    tick();
    check4("reseed F", 1'b1, 4'hF, 1'b1);
`endif

    // Asynchronous reset mid-stream
    tick();
    #2 rst_n = 1'b0;
    #1;
    check4("async rst", 1'b0, 4'h0, 1'b0);
    check_val("async rst lock", 32'(lock4), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check4("post rst sym0", 1'b1, 4'hF, 1'b1);
    tick();
    check4("post rst sym1", 1'b1, 4'h5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
